// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating count of inserted load-use bubbles.
module id_ex_pipeline_register #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      idValid,
  input  logic [DATA_WIDTH-1:0]     idPc,
  input  logic [DATA_WIDTH-1:0]     idReadData1,
  input  logic [DATA_WIDTH-1:0]     idReadData2,
  input  logic [DATA_WIDTH-1:0]     idImmediate,
  input  logic [REG_ADDR_WIDTH-1:0] idRs1,
  input  logic [REG_ADDR_WIDTH-1:0] idRs2,
  input  logic [REG_ADDR_WIDTH-1:0] idRd,
  input  logic [2:0]                idFunct3,
  input  logic                      idFunct7b5,
  input  logic [1:0]                idALUOp,
  input  logic                      idBranch,
  input  logic                      idRegWrite,
  input  logic                      idMemoryToRegister,
  input  logic                      idALUSrc,
  input  logic                      idMemoryRead,
  input  logic                      idMemoryWrite,
  input  logic                      flush,
  output logic                      exValid,
  output logic [DATA_WIDTH-1:0]     exPc,
  output logic [DATA_WIDTH-1:0]     exReadData1,
  output logic [DATA_WIDTH-1:0]     exReadData2,
  output logic [DATA_WIDTH-1:0]     exImmediate,
  output logic [REG_ADDR_WIDTH-1:0] exRs1,
  output logic [REG_ADDR_WIDTH-1:0] exRs2,
  output logic [REG_ADDR_WIDTH-1:0] exRd,
  output logic [2:0]                exFunct3,
  output logic                      exFunct7b5,
  output logic [1:0]                exALUOp,
  output logic                      exBranch,
  output logic                      exRegWrite,
  output logic                      exMemoryToRegister,
  output logic                      exALUSrc,
  output logic                      exMemoryRead,
  output logic                      exMemoryWrite,
  output logic                      stall,
  output logic [COUNT_WIDTH-1:0]    stallCount
);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == {COUNT_WIDTH{1'b1}}) ? c : c + 1'b1;
  endfunction

  logic usesRs2;
  logic loadUse;
  logic loadBubble;

  // Hazard check: load in EX whose destination feeds the instruction in ID
  assign usesRs2 = !idALUSrc || idMemoryWrite;
  assign loadUse = exValid && exMemoryRead && (exRd != '0) && idValid &&
                   ((exRd == idRs1) || (usesRs2 && (exRd == idRs2)));
  assign stall   = loadUse && !flush;

  // A bubble zeroes every field so exRd=0 can never match a forwarding path
  assign loadBubble = !reset || flush || stall || !idValid;

  // ID -> EX stage boundary
  always_ff @(posedge clock) begin
    if (loadBubble) begin
      exValid            <= 1'b0;
      exPc               <= '0;
      exReadData1        <= '0;
      exReadData2        <= '0;
      exImmediate        <= '0;
      exRs1              <= '0;
      exRs2              <= '0;
      exRd               <= '0;
      exFunct3           <= '0;
      exFunct7b5         <= 1'b0;
      exALUOp            <= '0;
      exBranch           <= 1'b0;
      exRegWrite         <= 1'b0;
      exMemoryToRegister <= 1'b0;
      exALUSrc           <= 1'b0;
      exMemoryRead       <= 1'b0;
      exMemoryWrite      <= 1'b0;
    end else begin
      exValid            <= 1'b1;
      exPc               <= idPc;
      exReadData1        <= idReadData1;
      exReadData2        <= idReadData2;
      exImmediate        <= idImmediate;
      exRs1              <= idRs1;
      exRs2              <= idRs2;
      exRd               <= idRd;
      exFunct3           <= idFunct3;
      exFunct7b5         <= idFunct7b5;
      exALUOp            <= idALUOp;
      exBranch           <= idBranch;
      exRegWrite         <= idRegWrite;
      exMemoryToRegister <= idMemoryToRegister;
      exALUSrc           <= idALUSrc;
      exMemoryRead       <= idMemoryRead;
      exMemoryWrite      <= idMemoryWrite;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stallCount <= '0;
    end else if (stall) begin
      stallCount <= sat_inc(stallCount);
    end
  end

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Bench for id_ex_pipeline_register: directed load-use/flush/saturation
// vectors plus a random phase, checked against an instruction-level model.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        v;
    logic [63:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  aluop;
    logic        br, rw, m2r, asrc, mr, mw;
  } instr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  instr_t id = '0;

  logic        exValid, exFunct7b5, exBranch, exRegWrite, exMemoryToRegister;
  logic        exALUSrc, exMemoryRead, exMemoryWrite, stall;
  logic [63:0] exPc, exReadData1, exReadData2, exImmediate;
  logic [4:0]  exRs1, exRs2, exRd;
  logic [2:0]  exFunct3;
  logic [1:0]  exALUOp;
  logic [3:0]  stallCount;

  int checks = 0;
  int errors = 0;

  instr_t m = '0;
  int     mcount = 0;
  bit     mvalid = 0;

  always #5 clock = ~clock;

  id_ex_pipeline_register #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .idValid(id.v), .idPc(id.pc),
    .idReadData1(id.rd1), .idReadData2(id.rd2), .idImmediate(id.imm),
    .idRs1(id.rs1), .idRs2(id.rs2), .idRd(id.rd), .idFunct3(id.f3),
    .idFunct7b5(id.f7), .idALUOp(id.aluop), .idBranch(id.br),
    .idRegWrite(id.rw), .idMemoryToRegister(id.m2r), .idALUSrc(id.asrc),
    .idMemoryRead(id.mr), .idMemoryWrite(id.mw), .flush(flush),
    .exValid(exValid), .exPc(exPc), .exReadData1(exReadData1),
    .exReadData2(exReadData2), .exImmediate(exImmediate), .exRs1(exRs1),
    .exRs2(exRs2), .exRd(exRd), .exFunct3(exFunct3), .exFunct7b5(exFunct7b5),
    .exALUOp(exALUOp), .exBranch(exBranch), .exRegWrite(exRegWrite),
    .exMemoryToRegister(exMemoryToRegister), .exALUSrc(exALUSrc),
    .exMemoryRead(exMemoryRead), .exMemoryWrite(exMemoryWrite),
    .stall(stall), .stallCount(stallCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A dependent instruction must wait one cycle behind a load of its source
  function automatic logic hazard(input instr_t ex, input instr_t d, input logic f);
    logic readsRs2;
    readsRs2 = !d.asrc || d.mw;
    return !f && ex.v && ex.mr && ex.rd != 0 && d.v &&
           (ex.rd == d.rs1 || (readsRs2 && ex.rd == d.rs2));
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m = '0; mcount = 0; mvalid = 1;
    end else if (mvalid) begin
      if (hazard(m, id, flush)) begin
        m = '0;
        if (mcount < 15) mcount++;
      end else if (flush || !id.v) m = '0;
      else m = id;
    end
  end

  always @(negedge clock) begin
    if (mvalid) begin
      chk("m.exValid", exValid, m.v);
      chk("m.exPc", exPc, m.pc);
      chk("m.exReadData1", exReadData1, m.rd1);
      chk("m.exReadData2", exReadData2, m.rd2);
      chk("m.exImmediate", exImmediate, m.imm);
      chk("m.exRs1", exRs1, m.rs1);
      chk("m.exRs2", exRs2, m.rs2);
      chk("m.exRd", exRd, m.rd);
      chk("m.exFunct3", exFunct3, m.f3);
      chk("m.exFunct7b5", exFunct7b5, m.f7);
      chk("m.exALUOp", exALUOp, m.aluop);
      chk("m.exBranch", exBranch, m.br);
      chk("m.exRegWrite", exRegWrite, m.rw);
      chk("m.exMemoryToRegister", exMemoryToRegister, m.m2r);
      chk("m.exALUSrc", exALUSrc, m.asrc);
      chk("m.exMemoryRead", exMemoryRead, m.mr);
      chk("m.exMemoryWrite", exMemoryWrite, m.mw);
      chk("m.stall", stall, hazard(m, id, flush));
      chk("m.stallCount", stallCount, mcount);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] d1, input logic [63:0] d2);
    id = '0;
    id.v = 1; id.aluop = 2'b10; id.rw = 1; id.rd = rd; id.rs1 = rs1; id.rs2 = rs2;
    id.rd1 = d1; id.rd2 = d2; id.pc = 64'h1000 + rd;
  endtask

  task automatic ld(input logic [4:0] rd);
    id = '0;
    id.v = 1; id.mr = 1; id.m2r = 1; id.rw = 1; id.asrc = 1; id.rd = rd; id.rs1 = 2;
    id.imm = 64'h8; id.f3 = 3'b011;
  endtask

  initial begin
    // Reset with live-looking decode inputs
    reset = 0;
    id = {1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'($urandom)};
    id.v = 1;
    tick(); tick();
    chk("reset exValid", exValid, 0);
    chk("reset exPc", exPc, 0);
    chk("reset exRd", exRd, 0);
    chk("reset stall", stall, 0);
    chk("reset stallCount", stallCount, 0);
    reset = 1;

    // R-format pass-through
    rtype(5, 1, 2, 64'h10, 64'h20);
    #1 chk("pass stall", stall, 0);
    tick();
    chk("pass exValid", exValid, 1);
    chk("pass exALUOp", exALUOp, 2'b10);
    chk("pass exRegWrite", exRegWrite, 1);
    chk("pass exRd", exRd, 5);
    chk("pass exReadData1", exReadData1, 64'h10);
    chk("pass exReadData2", exReadData2, 64'h20);

    // Load-use on rs1
    ld(7);
    tick();
    chk("ld exMemoryRead", exMemoryRead, 1);
    chk("ld exRd", exRd, 7);
    rtype(8, 7, 3, 64'h1, 64'h2);
    #1 chk("lu stall", stall, 1);
    tick();
    chk("lu bubble exValid", exValid, 0);
    chk("lu bubble exRegWrite", exRegWrite, 0);
    chk("lu stallCount", stallCount, 1);
    chk("lu released stall", stall, 0);
    tick();
    chk("lu add exValid", exValid, 1);
    chk("lu add exRd", exRd, 8);

    // Load to x0 never stalls
    ld(0);
    tick();
    rtype(9, 0, 4, 64'h3, 64'h4);
    #1 chk("x0 stall", stall, 0);
    tick();

    // ADDI ignores rs2, SD uses it
    ld(7);
    tick();
    id = '0; id.v = 1; id.asrc = 1; id.rw = 1; id.rs1 = 3; id.rs2 = 7; id.rd = 10;
    #1 chk("addi stall", stall, 0);
    id.rw = 0; id.mw = 1; id.rd = 0;
    #1 chk("sd stall", stall, 1);
    tick();
    chk("sd stallCount", stallCount, 2);
    tick();
    chk("sd exMemoryWrite", exMemoryWrite, 1);

    // Flush wins over a load-use hazard
    ld(7);
    tick();
    rtype(11, 7, 1, 64'h5, 64'h6);
    flush = 1;
    #1 chk("flush stall", stall, 0);
    tick();
    flush = 0;
    chk("flush exValid", exValid, 0);
    chk("flush stallCount", stallCount, 2);

    // Invalid decode slot becomes a bubble
    rtype(12, 1, 1, 64'h7, 64'h8);
    id.v = 0;
    tick();
    chk("idle exValid", exValid, 0);
    chk("idle exPc", exPc, 0);

    // Saturation: 13 hazards reach 15, one more must hold
    for (int i = 0; i < 14; i++) begin
      ld(7); tick();
      rtype(13, 7, 1, 64'h0, 64'h0); tick();
    end
    chk("sat stallCount", stallCount, 15);
    ld(6); tick();
    rtype(14, 1, 6, 64'h0, 64'h0);
    #1 chk("sat stall", stall, 1);
    tick();
    chk("sat hold stallCount", stallCount, 15);
    reset = 0;
    tick();
    chk("sat reset stallCount", stallCount, 0);
    chk("sat reset exValid", exValid, 0);
    reset = 1;

    // Random mix checked by the model
    for (int i = 0; i < 60; i++) begin
      id.v = ($urandom_range(0, 3) != 0);
      id.pc = {$urandom, $urandom}; id.rd1 = {$urandom, $urandom};
      id.rd2 = {$urandom, $urandom}; id.imm = {$urandom, $urandom};
      id.rs1 = 5'($urandom_range(0, 7)); id.rs2 = 5'($urandom_range(0, 7));
      id.rd = 5'($urandom_range(0, 7)); id.f3 = 3'($urandom);
      id.f7 = 1'($urandom); id.aluop = 2'($urandom); id.br = 1'($urandom);
      id.rw = 1'($urandom); id.m2r = 1'($urandom); id.asrc = 1'($urandom);
      id.mr = 1'($urandom); id.mw = 1'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Pipeline register between the decode stage (main controller, register file, immediate generator) and the execute stage (ALU controller, ALU, branch compare).
- Latches the decode-stage control signals (ALUOp, branch, regWrite, memoryToRegister, ALUSrc, memoryRead, memoryWrite) together with the operands and instruction fields.
- Contains load-use hazard detection: it stalls the front end and inserts a bubble when needed.
- Supports a flush on a taken branch, and keeps a saturating count of load-use stalls.

Parameters:
DATA_WIDTH, 64, width of PC, register operands and immediate (RV64, LD/SD)
REG_ADDR_WIDTH, 5, register index width
COUNT_WIDTH, 16, width of stall counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
idValid  input  1  decode stage holds a real instruction
idPc  input  DATA_WIDTH  PC of decode instruction
idReadData1  input  DATA_WIDTH  rs1 value
idReadData2  input  DATA_WIDTH  rs2 value
idImmediate  input  DATA_WIDTH  sign-extended immediate
idRs1, idRs2, idRd  input  REG_ADDR_WIDTH  register indices
idFunct3  input  3  instruction[14:12]
idFunct7b5  input  1  instruction[30]
idALUOp  input  2  from controller
idBranch, idRegWrite, idMemoryToRegister, idALUSrc, idMemoryRead, idMemoryWrite  input  1 each  from controller
flush  input  1  taken branch resolved; discard decode instruction
exValid  output  1  execute stage holds a real instruction
exPc, exReadData1, exReadData2, exImmediate  output  DATA_WIDTH  registered copies
exRs1, exRs2, exRd  output  REG_ADDR_WIDTH  registered copies
exFunct3  output  3  registered copy
exFunct7b5  output  1  registered copy
exALUOp  output  2  registered copy
exBranch, exRegWrite, exMemoryToRegister, exALUSrc, exMemoryRead, exMemoryWrite  output  1 each  registered copies
stall  output  1  combinational; hold PC and IF/ID register this cycle
stallCount  output  COUNT_WIDTH  saturating count of inserted load-use bubbles

Behaviour:
Reset:
- Reset when reset==0 at a rising edge.
- Every registered output goes to 0, including stallCount.
- stall is 0 while the registered state is reset.
- Reset overrides flush and stall.
- A reset asserted mid-stall discards the pending instruction. The front end re-presents it.

Hazard detection (combinational, from current ex* registers and id* inputs):
- usesRs2 = (idALUSrc==0) || (idMemoryWrite==1).
- loadUse = exValid && exMemoryRead && (exRd!=0) && idValid && ((exRd==idRs1) || (usesRs2 && exRd==idRs2)).
- stall = loadUse && !flush. When flush is high, the decode instruction is being discarded, so stall is never asserted.

Register update at each rising edge, reset==1, in priority order:
1. flush==1: capture a bubble.
2. stall==1: capture a bubble. stallCount increments by 1, saturating at all-ones (no wrap).
3. idValid==0: capture a bubble.
4. Otherwise: capture every id* field into the matching ex* register and set exValid=1.

Bubble definition:
- exValid=0, all ex* control outputs 0, exALUOp=00.
- All datapath and index fields 0, so exRd=0 and no forwarding match is possible.

Timing and rules:
- Latency: exactly 1 cycle from id* inputs to ex* outputs.
- No combinational path from id* inputs to ex* outputs.
- One load-use hazard produces stall for exactly one cycle. The following cycle EX holds a bubble, so loadUse is 0 and the held instruction is captured normally.
- Back-to-back loads with a dependency each stall once.
- Instruction fields are latched unconditionally, even for opcodes the controller does not decode. Gating is by exValid only.

Test Plan:
- Reset: drive reset=0 for 2 cycles with idValid=1 and random inputs → all outputs 0, stall=0, stallCount=0.
- Pass-through: R-format (idALUOp=10, idRegWrite=1, idRd=5, idReadData1=0x10, idReadData2=0x20) → next cycle exValid=1, exALUOp=10, exRegWrite=1, exRd=5, exReadData1=0x10, exReadData2=0x20; stall=0.
- Load-use on rs1: LD x7 captured (exMemoryRead=1, exRd=7), then decode add with idRs1=7 → stall=1 for one cycle, next edge bubble (exValid=0, exRegWrite=0), stallCount=1; following edge the add is captured with exValid=1.
- No false stall:
  - LD to exRd=0 followed by idRs1=0 → stall=0.
  - LD x7 followed by ADDI-type (idALUSrc=1, idMemoryWrite=0) with idRs2=7 and idRs1=3 → stall=0.
  - SD with idRs2=7 → stall=1.
- Flush vs stall: load-use condition present and flush=1 in the same cycle → stall=0, bubble captured, stallCount unchanged.
- Counter saturation: preload stallCount to all-ones (COUNT_WIDTH=4 → 15) via 15 hazards, then force one more → stallCount stays 15. Apply reset=0 → stallCount returns to 0.
